change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 19 +
 rtl/change_dispenser_coin_select.sv | 27 ++
 rtl/change_dispenser.sv | 134 +++++++++++++
 tb/tb_change_dispenser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared soda-machine constants and the change dispenser state encoding.
package change_dispenser_pkg;

  localparam int unsigned NICKEL  = 5;
  localparam int unsigned DIME    = 10;
  localparam int unsigned QUARTER = 25;

  localparam int unsigned CNT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_SELECT  = 3'd2,
    ST_SEND    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding rem, plus a flag for a
// 1-4 cent residue that no coin can return.
module coin_select
  import change_dispenser_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] rem,
  output logic [W-1:0] coin,
  output logic         residue
);

  localparam logic [W-1:0] Q_V = W'(QUARTER);
  localparam logic [W-1:0] D_V = W'(DIME);
  localparam logic [W-1:0] N_V = W'(NICKEL);

  // Pick the largest coin that fits; zero when nothing fits.
  always_comb begin
    coin    = '0;
    residue = 1'b0;
    if (rem >= Q_V)      coin = Q_V;
    else if (rem >= D_V) coin = D_V;
    else if (rem >= N_V) coin = N_V;
    else                 residue = (rem != '0);
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: on a rising edge of d, computes tot - s (clamped at 0)
// and returns it greedily as quarters, dimes and nickels, one coin per
// full ack handshake with the hopper.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d,
  input  logic [W-1:0] tot,
  input  logic [W-1:0] s,
  input  logic         ack,
  output logic         cv,
  output logic [W-1:0] a,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [4:0]   cnt
);

  state_t       state, state_n;
  logic         d_q, armed, rise;
  logic [W-1:0] tot_q, s_q, rem;
  logic [W-1:0] tot_n, s_n, rem_n, a_n;
  logic         cv_n, busy_n, done_n, err_n;
  logic [4:0]   cnt_n;
  logic [W-1:0] coin;
  logic         residue;

  coin_select #(.W(W)) u_coin_select (
    .rem     (rem),
    .coin    (coin),
    .residue (residue)
  );

  // Edge detect on d; armed stays low after reset until d is seen low, so a
  // level already high at reset release cannot start a transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      d_q   <= d;
      if (!d) armed <= 1'b1;
    end
  end

  assign rise = d & ~d_q & armed;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; edges of d outside IDLE are simply dropped.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (rise) state_n = ST_CALC;
      ST_CALC:    state_n = ST_SELECT;
      ST_SELECT:  state_n = (coin != '0) ? ST_SEND : ST_DONE;
      ST_SEND:    if (ack)  state_n = ST_RELEASE;
      ST_RELEASE: if (!ack) state_n = ST_SELECT;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Next values for the registered datapath and outputs.
  always_comb begin
    tot_n  = tot_q;
    s_n    = s_q;
    rem_n  = rem;
    a_n    = a;
    cv_n   = cv;
    err_n  = err;
    cnt_n  = cnt;
    done_n = (state == ST_DONE);
    busy_n = (state_n != ST_IDLE);
    unique case (state)
      ST_IDLE: if (rise) begin
        tot_n = tot;
        s_n   = s;
        cnt_n = '0;
        err_n = 1'b0;
      end
      ST_CALC: rem_n = (tot_q >= s_q) ? (tot_q - s_q) : '0;
      ST_SELECT: begin
        if (coin != '0) begin
          cv_n = 1'b1;
          a_n  = coin;
        end else if (residue) begin
          err_n = 1'b1;
        end
      end
      ST_SEND: if (ack) begin
        rem_n = rem - a;
        cnt_n = (cnt == 5'd31) ? cnt : cnt + 5'd1;
        cv_n  = 1'b0;
        a_n   = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_q <= '0;
      s_q   <= '0;
      rem   <= '0;
      a     <= '0;
      cv    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      tot_q <= tot_n;
      s_q   <= s_n;
      rem   <= rem_n;
      a     <= a_n;
      cv    <= cv_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a hand-driven coin hopper.
module tb_change_dispenser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         d;
  logic [W-1:0] tot, s;
  logic         ack;
  logic         cv;
  logic [W-1:0] a;
  logic         busy, done, err;
  logic [4:0]   cnt;

  int checks = 0;
  int errors = 0;

  change_dispenser #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .tot  (tot),
    .s    (s),
    .ack  (ack),
    .cv   (cv),
    .a    (a),
    .busy (busy),
    .done (done),
    .err  (err),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise d so the next clock edge (E) sees the rising edge; return at E+1ns.
  task automatic start(input logic [W-1:0] t, input logic [W-1:0] p);
    tot = t;
    s   = p;
    d   = 1'b1;
    tick();
    d   = 1'b0;
  endtask

  // Wait (bounded) for cv, check the coin, then do one full ack handshake.
  task automatic serve(input string tag, input logic [W-1:0] exp_a);
    int n = 0;
    while (!cv && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_cv"}, cv, 1);
    chk({tag, "_a"}, a, exp_a);
    ack = 1'b1;
    tick();
    chk({tag, "_cv_drop"}, cv, 0);
    ack = 1'b0;
    tick();
  endtask

  // Wait (bounded) for done with no further coin requests, then check totals.
  task automatic finish_txn(input string tag, input logic [4:0] exp_cnt, input logic exp_err);
    int  n = 0;
    logic saw_cv = 1'b0;
    while (!done && n < 30) begin
      if (cv) saw_cv = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_no_extra_cv"}, saw_cv, 0);
    chk({tag, "_cnt"}, cnt, exp_cnt);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; tot = '0; s = '0; ack = 1'b0;
    #1;
    chk("rst_cv", cv, 0);
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // 165 - 150 = 15 -> dime, nickel
    start(8'd165, 8'd150);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_cv_e1", cv, 0);
    tick();
    chk("t1_cv_e2", cv, 1);
    serve("t1_c1", 8'd10);
    chk("t1_cnt_mid", cnt, 1);
    serve("t1_c2", 8'd5);
    finish_txn("t1", 5'd2, 1'b0);

    // exact payment: done exactly at E+3
    start(8'd140, 8'd140);
    tick();
    chk("t2_done_e1", done, 0);
    tick();
    chk("t2_cv_e2", cv, 0);
    chk("t2_done_e2", done, 0);
    tick();
    chk("t2_done_e3", done, 1);
    chk("t2_cnt", cnt, 0);
    chk("t2_busy_e3", busy, 0);
    tick();
    chk("t2_done_e4", done, 0);

    // underpayment clamps to zero change
    start(8'd100, 8'd150);
    finish_txn("t3", 5'd0, 1'b0);

    // 183 cents: seven quarters, a nickel, 3 cents unreturnable
    start(8'd200, 8'd17);
    for (int i = 0; i < 7; i++) serve("t4_q", 8'd25);
    serve("t4_n", 8'd5);
    finish_txn("t4", 5'd8, 1'b1);
    tick(); tick();
    chk("t4_err_held", err, 1);

    // hopper stalls 20 cycles with extra d pulses; next start clears err
    start(8'd165, 8'd150);
    chk("t5_err_cleared", err, 0);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      d = (i % 4 == 1);
      tick();
      chk("t5_cv_hold", cv, 1);
      chk("t5_a_hold", a, 10);
    end
    d = 1'b0;
    serve("t5_c1", 8'd10);
    serve("t5_c2", 8'd5);
    finish_txn("t5", 5'd2, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_no_requeue", busy, 0);

    // asynchronous reset in the middle of SEND
    start(8'd165, 8'd150);
    tick(); tick();
    chk("t6_in_send", cv, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cv", cv, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_a", a, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    start(8'd165, 8'd150);
    serve("t6_c1", 8'd10);
    serve("t6_c2", 8'd5);
    finish_txn("t6", 5'd2, 1'b0);

    // d already high across reset release must not start a transaction
    rst = 1'b1; d = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t7_no_start", busy, 0);
    d = 1'b0;
    tick();
    start(8'd30, 8'd5);
    serve("t7_q", 8'd25);
    finish_txn("t7", 5'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
